// File: rtl/ring_pkg.sv
// Shared definitions for the ring router: flit geometry defaults, VC encoding
// and the hop-field update applied to every flit leaving an output port.
package ring_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int HOP_LSB_DEF    = 48;
  localparam int HOP_W_DEF      = 8;

  localparam int VC_EVEN = 0;
  localparam int VC_ODD  = 1;

  localparam int FLIT_MAX_W = 512;
  typedef logic [FLIT_MAX_W-1:0] flit_max_t;

  // Shifts only the hop field right by one; the field's top bit fills with zero.
  function automatic flit_max_t hop_decrement(flit_max_t flit, int lsb, int w);
    flit_max_t mask;
    mask = ((flit_max_t'(1) << w) - flit_max_t'(1)) << lsb;
    return (flit & ~mask) | (((flit & mask) >> 1) & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// around, and reports the winner both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/ring_vc_output_arbiter.sv
// Ring router output port: per-VC one-flit buffer with round-robin input
// selection, draining onto the link on the VC chosen by the global polarity.
module ring_vc_output_arbiter
  import ring_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = 2,
  parameter int HOP_LSB    = HOP_LSB_DEF,
  parameter int HOP_W      = HOP_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         polarity,
  input  logic                         out_ro,
  input  logic [NUM_IN-1:0]            req_even,
  input  logic [NUM_IN-1:0]            req_odd,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in_even,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in_odd,
  output logic [NUM_IN-1:0]            gnt_even,
  output logic [NUM_IN-1:0]            gnt_odd,
  output logic                         out_so,
  output logic [DATA_WIDTH-1:0]        out_do,
  output logic                         full_even,
  output logic                         full_odd
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]            req_vc [2];
  logic [NUM_IN*DATA_WIDTH-1:0] din_vc [2];
  logic [NUM_IN-1:0]            gnt_vc [2];

  assign req_vc[VC_EVEN] = req_even;
  assign req_vc[VC_ODD]  = req_odd;
  assign din_vc[VC_EVEN] = data_in_even;
  assign din_vc[VC_ODD]  = data_in_odd;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic                  full;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [PW-1:0]         ptr;
    logic                  drain;
    logic                  acc;
    logic                  en;
    logic [PW-1:0]         idx;

    assign drain = full & out_ro & (polarity == 1'(v));
    assign acc   = (~full | drain) & (|req_vc[v]);
    // Gating with rst makes grants disappear the instant reset asserts.
    assign en    = acc & rst;

    rr_arbiter #(.N(NUM_IN), .PW(PW)) u_arb (
      .req (req_vc[v]),
      .ptr (ptr),
      .en  (en),
      .gnt (gnt_vc[v]),
      .idx (idx)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        full  <= 1'b0;
        buf_q <= '0;
        ptr   <= '0;
      end else if (acc) begin
        full  <= 1'b1;
        buf_q <= din_vc[v][idx*DATA_WIDTH +: DATA_WIDTH];
        ptr   <= (idx == PW'(NUM_IN - 1)) ? '0 : idx + PW'(1);
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

  assign gnt_even  = gnt_vc[VC_EVEN];
  assign gnt_odd   = gnt_vc[VC_ODD];
  assign full_even = g_vc[VC_EVEN].full;
  assign full_odd  = g_vc[VC_ODD].full;

  logic                  drain_any;
  logic [DATA_WIDTH-1:0] drain_flit;

  assign drain_any  = polarity ? g_vc[VC_ODD].drain : g_vc[VC_EVEN].drain;
  assign drain_flit = polarity ? g_vc[VC_ODD].buf_q : g_vc[VC_EVEN].buf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_so <= 1'b0;
      out_do <= '0;
    end else begin
      out_so <= drain_any;
      if (drain_any)
        out_do <= DATA_WIDTH'(hop_decrement(flit_max_t'(drain_flit), HOP_LSB, HOP_W));
    end
  end

endmodule

// File: tb/tb_ring_vc_output_arbiter.sv
// Directed bench for ring_vc_output_arbiter (NUM_IN=4); outgoing flits are
// checked by a scoreboard monitor against hand-computed expected flits.
module tb_ring_vc_output_arbiter;

  localparam int DW = 64;
  localparam int NI = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             polarity;
  logic             out_ro;
  logic [NI-1:0]    req_even;
  logic [NI-1:0]    req_odd;
  logic [NI*DW-1:0] data_in_even;
  logic [NI*DW-1:0] data_in_odd;
  logic [NI-1:0]    gnt_even;
  logic [NI-1:0]    gnt_odd;
  logic             out_so;
  logic [DW-1:0]    out_do;
  logic             full_even;
  logic             full_odd;

  int tests  = 0;
  int failed = 0;
  logic [DW-1:0] exp_q[$];

  ring_vc_output_arbiter #(.DATA_WIDTH(DW), .NUM_IN(NI), .HOP_LSB(48), .HOP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .polarity     (polarity),
    .out_ro       (out_ro),
    .req_even     (req_even),
    .req_odd      (req_odd),
    .data_in_even (data_in_even),
    .data_in_odd  (data_in_odd),
    .gnt_even     (gnt_even),
    .gnt_odd      (gnt_odd),
    .out_so       (out_so),
    .out_do       (out_do),
    .full_even    (full_even),
    .full_odd     (full_odd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every flit that leaves must be the next one the stimulus announced.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_so === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("[TB] FAIL unexpected_flit: got 0x%0h, expected no output", out_do);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_do !== e) begin
          failed++;
          $display("[TB] FAIL out_do: got 0x%0h, expected 0x%0h", out_do, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  localparam logic [NI-1:0] ONEHOT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [DW-1:0] ODD_IN  [4] = '{64'hC010_0000_0000_0000, 64'hC120_0000_0000_0001,
                                            64'hC241_0000_0000_0002, 64'hC3FF_0000_0000_0003};
  localparam logic [DW-1:0] ODD_EXP [4] = '{64'hC008_0000_0000_0000, 64'hC110_0000_0000_0001,
                                            64'hC220_0000_0000_0002, 64'hC37F_0000_0000_0003};

  initial begin
    rst = 1'b0; polarity = 1'b0; out_ro = 1'b1;
    req_even = '1; req_odd = '1;
    data_in_even = '0; data_in_odd = '0;

    // Reset with every request raised.
    repeat (3) tick();
    check("rst_gnt_even", gnt_even, 0);
    check("rst_gnt_odd",  gnt_odd,  0);
    check("rst_out_so",   out_so,   0);
    check("rst_out_do",   out_do,   0);
    check("rst_full_even", full_even, 0);
    check("rst_full_odd",  full_odd,  0);
    rst = 1'b1;
    #1;
    check("rel_gnt_even", gnt_even, 4'b0001);
    check("rel_gnt_odd",  gnt_odd,  4'b0001);
    req_even = '0; req_odd = '0;
    tick();

    // Single flit on even VC, channel 1, hop 0x04 -> 0x02.
    req_even = 4'b0010;
    data_in_even[1*DW +: DW] = 64'hA504_1234_5678_9ABC;
    #1;
    check("single_gnt", gnt_even, 4'b0010);
    check("single_full_pre", full_even, 0);
    exp_q.push_back(64'hA502_1234_5678_9ABC);
    tick();
    req_even = '0;
    #1;
    check("single_gnt_after", gnt_even, 0);
    check("single_full", full_even, 1);
    tick();
    check("single_drained", full_even, 0);

    // Fairness on odd VC with all four channels requesting.
    polarity = 1'b1;
    for (int i = 0; i < NI; i++) data_in_odd[i*DW +: DW] = ODD_IN[i];
    req_odd = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("fair_gnt_%0d", k), gnt_odd, ONEHOT[k]);
      exp_q.push_back(ODD_EXP[k % NI]);
      tick();
    end
    req_odd = '0;
    tick();
    check("fair_full_odd", full_odd, 0);

    // Backpressure: accept while empty, then hold with out_ro low.
    polarity = 1'b0; out_ro = 1'b0;
    req_even = 4'b0100;
    data_in_even[2*DW +: DW] = 64'h0100_0000_0000_00EE;
    #1;
    check("bp_gnt_load", gnt_even, 4'b0100);
    exp_q.push_back(64'h0100_0000_0000_00EE);
    tick();
    req_even = 4'b1000;
    data_in_even[3*DW +: DW] = 64'h7E81_FFFF_0000_1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_gnt_%0d", k), gnt_even, 0);
      check($sformatf("bp_so_%0d", k), out_so, 0);
      tick();
    end
    out_ro = 1'b1;
    #1;
    check("bp_refill_gnt", gnt_even, 4'b1000);
    exp_q.push_back(64'h7E40_FFFF_0000_1111);
    tick();
    req_even = '0;
    #1;
    check("bp_refill_full", full_even, 1);
    tick();
    check("bp_final_full", full_even, 0);

    // Polarity isolation with both buffers loaded.
    out_ro = 1'b0;
    req_even = 4'b0001;
    req_odd  = 4'b0010;
    data_in_even[0*DW +: DW] = 64'h1122_3344_5566_7788;
    data_in_odd[1*DW +: DW]  = 64'h99FE_0000_0000_0042;
    #1;
    check("pol_gnt_even", gnt_even, 4'b0001);
    check("pol_gnt_odd",  gnt_odd,  4'b0010);
    exp_q.push_back(64'h1111_3344_5566_7788);
    exp_q.push_back(64'h997F_0000_0000_0042);
    tick();
    req_even = '0; req_odd = '0;
    out_ro = 1'b1; polarity = 1'b0;
    #1;
    check("pol_full_both", {full_even, full_odd}, 2'b11);
    tick();
    polarity = 1'b1;
    #1;
    check("pol_after_even", {full_even, full_odd}, 2'b01);
    tick();
    check("pol_after_odd", full_odd, 0);

    // Mid-operation reset discards the odd buffer.
    out_ro = 1'b0;
    req_odd = 4'b0100;
    data_in_odd[2*DW +: DW] = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("mrst_gnt_load", gnt_odd, 4'b0100);
    tick();
    req_odd = '0;
    #1;
    check("mrst_full_pre", full_odd, 1);
    rst = 1'b0;
    req_odd = 4'b0001;
    #1;
    check("mrst_full", full_odd, 0);
    check("mrst_gnt", gnt_odd, 0);
    check("mrst_out_do", out_do, 0);
    req_odd = '0;
    out_ro = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("mrst_out_do_hold", out_do, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
